mux_pipe: RTL
=============

# mux_pipe

Parametrised N-input datapath multiplexer with a registered output stage and valid/ready flow control, for the pipelined core. It generalises the fixed 4-input combinational select to 2..16 inputs of arbitrary width. A 2-entry skid buffer lets it sit between pipeline stages without breaking back-pressure timing. It flags out-of-range selects instead of producing undefined data and supports a synchronous flush for branch/trap recovery.

## Interface
- DATA_WIDTH, 32, width of each data input and of `out`
- NUM_INPUTS, 4, number of selectable inputs; legal range 2..16
- CONTROL_WIDTH, 2, width of `control`; must be >= $clog2(NUM_INPUTS); elaboration error otherwise
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- control  input  CONTROL_WIDTH  select index, sampled with the input beat
- in_data  input  NUM_INPUTS*DATA_WIDTH  packed inputs; input k = in_data[k*DATA_WIDTH +: DATA_WIDTH]
- in_valid  input  1  upstream beat valid
- in_ready  output  1  block can accept a beat this cycle
- flush  input  1  synchronous discard of all held beats
- out  output  DATA_WIDTH  selected data of the head beat
- out_valid  output  1  `out`/`sel_err` valid
- out_ready  input  1  downstream accepts head beat
- sel_err  output  1  head beat had control >= NUM_INPUTS
- err_sticky  output  1  set on any accepted out-of-range select; cleared only by reset

## Operation
- Storage: output register (OR: data, err, valid) and skid register (SK: data, err, valid).
- Accept = in_valid && in_ready && !flush.
- Selected value: in_data slice `control` when control < NUM_INPUTS; otherwise all-zero data with err = 1.
- in_ready = !SK.valid. It is a register-only function with no combinational path from out_ready.
- Pop = out_valid && out_ready.
- Per-cycle update, in priority order:
  - flush: OR.valid <= 0 and SK.valid <= 0. Any beat offered in the same cycle is dropped, and err_sticky is not updated for it.
  - Pop with SK full: OR <= SK. If accepting, SK <= new beat; else SK.valid <= 0. In practice in_ready is 0 here, so no accept.
  - Pop with SK empty: OR <= new beat if accepting; else OR.valid <= 0.
  - No pop, OR empty: OR <= new beat if accepting.
  - No pop, OR full: SK <= new beat if accepting.
- err_sticky <= 1 on any accept with an out-of-range select.
- out and sel_err reflect OR. Data values are held when invalid, but are don't-care.
- Ordering is strict FIFO: SK is never emitted before OR.

## Timing
- Reset (async assert, synchronous deassert by the integrating clock domain) values:
  - out = 0, sel_err = 0, out_valid = 0
  - SK.valid = 0, so in_ready = 1
  - err_sticky = 0
- Latency: a beat accepted at edge n is visible on out/out_valid after edge n, i.e. 1 cycle.
- Throughput: 1 beat/cycle while out_ready = 1.
- out_ready low for one cycle:
  - Next beat lands in SK and in_ready drops after that edge.
  - in_ready rises again one cycle after the SK drain.
- Full (OR and SK valid): in_ready = 0 and upstream holds. No beat is lost or duplicated.
- Reset mid-operation: all valids cleared immediately (asynchronously). Held beats are discarded.
- A flush asserted while OR is valid and out_ready = 1 still discards OR. A downstream that sees out_valid && out_ready in a flush cycle must treat the beat as squashed.

## Test plan
- Reset then NUM_INPUTS=4, DATA_WIDTH=32, input k = 0x1000_0000+k, control=2, single beat with out_ready=1 -> out=0x1000_0002, out_valid=1 exactly one cycle after accept, sel_err=0.
- Streaming with control cycling 0..3 and out_ready=1 -> outputs 0x1000_0000..0x1000_0003 on consecutive cycles; in_ready stays 1.
- Back-pressure: out_ready=0 for 3 cycles while sending beats A, B, C -> A held on out, B in SK, in_ready=0 from the cycle after B, C held upstream; release gives A, B, C in order with no loss.
- NUM_INPUTS=3, CONTROL_WIDTH=2, control=3 -> out=0, sel_err=1, err_sticky=1; err_sticky stays 1 after later legal beats and after flush, and clears only on rst_n=0.
- Flush with OR and SK full and in_valid=1 -> next cycle out_valid=0, in_ready=1; offered beat is not emitted.
- Assert rst_n=0 mid-stream, asynchronously between clock edges -> out_valid=0, out=0, in_ready=1 before the next edge.

Source files
------------

// File: rtl/mux_pipe.sv
// N-input registered select with a 2-entry (output + skid) valid/ready stage.
// Latency 1 cycle; in_ready depends only on the skid valid bit, so it never waits on out_ready combinationally.
module mux_pipe #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_INPUTS    = 4,
    parameter int CONTROL_WIDTH = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [CONTROL_WIDTH-1:0]        control,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            flush,
    output logic [DATA_WIDTH-1:0]           out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            sel_err,
    output logic                            err_sticky
);

    generate
        if (NUM_INPUTS < 2 || NUM_INPUTS > 16) begin : g_bad_num_inputs
            $error("mux_pipe: NUM_INPUTS must be in 2..16");
        end
        if (CONTROL_WIDTH < $clog2(NUM_INPUTS)) begin : g_bad_control_width
            $error("mux_pipe: CONTROL_WIDTH too narrow for NUM_INPUTS");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_or_dat;
    logic                  r_or_err;
    logic                  r_or_vld;
    logic [DATA_WIDTH-1:0] r_sk_dat;
    logic                  r_sk_err;
    logic                  r_sk_vld;
    logic                  r_err_sticky;

    logic [DATA_WIDTH-1:0] w_sel_dat;
    logic                  w_sel_err;
    logic                  w_accept;
    logic                  w_pop;

    // Out-of-range selects fall through the loop with zero data and the error flag set.
    always_comb begin
        w_sel_dat = '0;
        w_sel_err = 1'b1;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (control == CONTROL_WIDTH'(k)) begin
                w_sel_dat = in_data[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_err = 1'b0;
            end
        end
    end

    assign in_ready = !r_sk_vld;
    assign w_accept = in_valid && in_ready && !flush;
    assign w_pop    = r_or_vld && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_or_dat <= '0;
            r_or_err <= 1'b0;
            r_or_vld <= 1'b0;
            r_sk_dat <= '0;
            r_sk_err <= 1'b0;
            r_sk_vld <= 1'b0;
        end else if (flush) begin
            r_or_vld <= 1'b0;
            r_sk_vld <= 1'b0;
        end else if (w_pop && r_sk_vld) begin
            r_or_dat <= r_sk_dat;
            r_or_err <= r_sk_err;
            r_or_vld <= 1'b1;
            if (w_accept) begin
                r_sk_dat <= w_sel_dat;
                r_sk_err <= w_sel_err;
            end else begin
                r_sk_vld <= 1'b0;
            end
        end else if (w_pop || !r_or_vld) begin
            // Output slot is free this cycle: refill directly, skid stays empty.
            if (w_accept) begin
                r_or_dat <= w_sel_dat;
                r_or_err <= w_sel_err;
                r_or_vld <= 1'b1;
            end else begin
                r_or_vld <= 1'b0;
            end
        end else if (w_accept) begin
            r_sk_dat <= w_sel_dat;
            r_sk_err <= w_sel_err;
            r_sk_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sticky <= 1'b0;
        end else if (w_accept && w_sel_err) begin
            r_err_sticky <= 1'b1;
        end
    end

    assign out        = r_or_dat;
    assign out_valid  = r_or_vld;
    assign sel_err    = r_or_err;
    assign err_sticky = r_err_sticky;

endmodule
